// File: rtl/ntt_pkg.sv
// Shared NTT definitions: scheduler state encoding, default geometry and
// datapath widths reused by the butterfly and coefficient storage.
package ntt_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} bf_state_t;

  localparam int LOGN_DEF   = 3;
  localparam int BF_LAT_DEF = 3;

  localparam int DATA_SIZE_ARB = 32;
  localparam int COEF_W        = DATA_SIZE_ARB;
  localparam int PROD_W        = 2 * DATA_SIZE_ARB;

endpackage

// File: rtl/ntt_wb_delay.sv
// Fixed-latency delay line that replays each issued butterfly (valid bit and
// address pair) at the moment its result leaves the butterfly pipeline.
module ntt_wb_delay #(
  parameter int BF_LAT = 3,
  parameter int WIDTH  = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] pipe [BF_LAT];

  // NOTE: non-blocking assignments let every stage sample its predecessor's
  // old value, so the loop below shifts by exactly one slot per clock.
  always_ff @(posedge clk) begin
    if (clr) begin
      // NOTE: every slot is cleared (not just the output) so a butterfly
      // issued before reset can never surface later as a stray write-back.
      for (int i = 0; i < BF_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= d;
      for (int i = 1; i < BF_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign q = pipe[BF_LAT-1];

endmodule

// File: rtl/ntt_bf_sched.sv
// In-place iterative NTT butterfly scheduler: issues one butterfly per cycle,
// stage by stage, draining the butterfly pipeline between stages.
module ntt_bf_sched
  import ntt_pkg::*;
#(
  parameter int LOGN   = LOGN_DEF,
  parameter int BF_LAT = BF_LAT_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [LOGN-1:0] stage,
  output logic            rd_en,
  output logic [LOGN-1:0] rd_addr0,
  output logic [LOGN-1:0] rd_addr1,
  output logic [LOGN-2:0] tw_addr,
  output logic            wr_en,
  output logic [LOGN-1:0] wr_addr0,
  output logic [LOGN-1:0] wr_addr1
);

  localparam int AW   = LOGN;
  localparam int JW   = LOGN - 1;
  localparam int CW   = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;
  localparam int WB_W = 2 * AW + 1;

  localparam logic [JW-1:0] LAST_J   = '1;
  localparam logic [AW-1:0] LAST_S   = AW'(LOGN - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(BF_LAT - 1);

  typedef struct packed {
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic [AW-2:0] tw;
  } bf_addr_t;

  // Butterfly j of stage s: the pair sits h = 2^s apart inside group j >> s.
  function automatic bf_addr_t bf_addr(input logic [JW-1:0] j,
                                       input logic [AW-1:0] s);
    logic [AW-1:0] jx, h, off, grp, tw_full;
    bf_addr_t r;
    jx      = AW'(j);
    h       = AW'(1) << s;
    off     = jx & (h - AW'(1));
    grp     = jx >> s;
    r.a0    = (grp << (s + AW'(1))) | off;
    r.a1    = r.a0 + h;
    tw_full = off << (AW'(LOGN - 1) - s);
    r.tw    = tw_full[AW-2:0];
    return r;
  endfunction

  bf_state_t     state;
  logic [JW-1:0] j;
  logic [CW-1:0] drain_cnt;

  logic [JW-1:0] issue_j;
  logic [AW-1:0] issue_s;
  bf_addr_t      nxt;

  logic [WB_W-1:0] wb_q;

  // Butterfly that would be issued at the coming edge, if the FSM issues one.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal
    // unassigned and infers a latch.
    issue_j = '0;
    issue_s = '0;
    case (state)
      RUN:     begin issue_j = j + JW'(1); issue_s = stage;          end
      DRAIN:   begin issue_j = '0;         issue_s = stage + AW'(1); end
      default: ;
    endcase
    nxt = bf_addr(issue_j, issue_s);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      j         <= '0;
      drain_cnt <= '0;
      stage     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr0  <= '0;
      rd_addr1  <= '0;
      tw_addr   <= '0;
    end else begin
      done     <= 1'b0;
      rd_en    <= 1'b0;
      rd_addr0 <= '0;
      rd_addr1 <= '0;
      tw_addr  <= '0;
      case (state)
        IDLE: if (start) begin
          state <= RUN;
          j     <= '0;
          stage <= '0;
          busy  <= 1'b1;
          {rd_en, rd_addr0, rd_addr1, tw_addr} <= {1'b1, nxt};
        end
        RUN: begin
          if (j == LAST_J) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end else begin
            j <= issue_j;
            {rd_en, rd_addr0, rd_addr1, tw_addr} <= {1'b1, nxt};
          end
        end
        // Last write-back of the stage is on the bus when the count expires.
        DRAIN: begin
          if (drain_cnt == LAST_CNT) begin
            if (stage == LAST_S) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              stage <= issue_s;
              j     <= '0;
              {rd_en, rd_addr0, rd_addr1, tw_addr} <= {1'b1, nxt};
            end
          end else begin
            drain_cnt <= drain_cnt + CW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  ntt_wb_delay #(
    .BF_LAT (BF_LAT),
    .WIDTH  (WB_W)
  ) u_wb_delay (
    .clk (clk),
    .clr (reset),
    .d   ({rd_en, rd_addr0, rd_addr1}),
    .q   (wb_q)
  );

  assign {wr_en, wr_addr0, wr_addr1} = wb_q;

endmodule

// File: tb/tb_ntt_bf_sched.sv
// Scoreboard bench for ntt_bf_sched: a textbook NTT loop model predicts every
// read, write-back, busy and done cycle; a negedge monitor compares.
module tb_ntt_bf_sched;

  localparam int LOGN   = 3;
  localparam int BF_LAT = 3;
  localparam int N      = 1 << LOGN;
  localparam int P      = N / 2 + BF_LAT;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic            busy, done, rd_en, wr_en;
  logic [LOGN-1:0] stage, rd_addr0, rd_addr1, wr_addr0, wr_addr1;
  logic [LOGN-2:0] tw_addr;

  ntt_bf_sched #(.LOGN(LOGN), .BF_LAT(BF_LAT)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .stage    (stage),
    .rd_en    (rd_en),
    .rd_addr0 (rd_addr0),
    .rd_addr1 (rd_addr1),
    .tw_addr  (tw_addr),
    .wr_en    (wr_en),
    .wr_addr0 (wr_addr0),
    .wr_addr1 (wr_addr1)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int stage;
    int a0;
    int a1;
    int tw;
  } ev_t;

  ev_t rd_q[$];
  ev_t wr_q[$];

  int cyc       = 0;
  int busy_lo   = 1;
  int busy_hi   = 0;
  int done_cyc  = -1;
  int idle_from = 1 << 30;
  bit mon_en    = 1'b0;
  int n_cmp     = 0;
  int n_fail    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference schedule: the classic in-place loop nest over blocks of 2h.
  task automatic push_run(input int c);
    int base, idx, h;
    ev_t e;
    base = c + 1;
    for (int s = 0; s < LOGN; s++) begin
      h   = 1 << s;
      idx = 0;
      for (int blk = 0; blk < N; blk += 2 * h) begin
        for (int k = 0; k < h; k++) begin
          e.cyc   = base + s * P + idx;
          e.stage = s;
          e.a0    = blk + k;
          e.a1    = blk + k + h;
          e.tw    = k * (N / (2 * h));
          rd_q.push_back(e);
          e.cyc = e.cyc + BF_LAT;
          wr_q.push_back(e);
          idx++;
        end
      end
    end
    busy_lo   = base;
    busy_hi   = base + LOGN * P - 1;
    done_cyc  = base + LOGN * P;
    idle_from = done_cyc + 1;
  endtask

  // Reset asserted during cycle x: nothing predicted after x survives.
  task automatic purge(input int x);
    while (rd_q.size() > 0 && rd_q[rd_q.size()-1].cyc > x) rd_q.delete(rd_q.size()-1);
    while (wr_q.size() > 0 && wr_q[wr_q.size()-1].cyc > x) wr_q.delete(wr_q.size()-1);
    if (busy_hi > x) busy_hi = x;
    if (done_cyc > x) done_cyc = -1;
  endtask

  task automatic cycle_drive(input bit st);
    start = st;
    if (st && cyc >= idle_from) push_run(cyc);
    step();
    start = 1'b0;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_busy"},     32'(busy),     0);
    check({tag, "_done"},     32'(done),     0);
    check({tag, "_stage"},    32'(stage),    0);
    check({tag, "_rd_en"},    32'(rd_en),    0);
    check({tag, "_rd_addr0"}, 32'(rd_addr0), 0);
    check({tag, "_rd_addr1"}, 32'(rd_addr1), 0);
    check({tag, "_tw_addr"},  32'(tw_addr),  0);
    check({tag, "_wr_en"},    32'(wr_en),    0);
    check({tag, "_wr_addr0"}, 32'(wr_addr0), 0);
    check({tag, "_wr_addr1"}, 32'(wr_addr1), 0);
  endtask

  // One run from the current (idle) cycle; optional stray starts while busy.
  task automatic run(input int noise_pct, input bit forced);
    int c0, limit;
    bit st;
    c0 = cyc;
    cycle_drive(1'b1);
    limit = idle_from;
    while (cyc < limit) begin
      st = ($urandom_range(0, 99) < noise_pct);
      if (forced && (cyc == c0 + 1 + P + 1 || cyc == limit - 1)) st = 1'b1;
      cycle_drive(st);
    end
  endtask

  // Monitor: every cycle, each strobe must match the scoreboard head.
  always @(negedge clk) begin
    if (mon_en) begin
      ev_t e;
      bit exp_rd, exp_wr;
      exp_rd = rd_q.size() > 0 && rd_q[0].cyc == cyc;
      check("rd_en", 32'(rd_en), 32'(exp_rd));
      if (exp_rd) begin
        e = rd_q.pop_front();
        if (rd_en) begin
          check("rd_stage", 32'(stage),    e.stage);
          check("rd_addr0", 32'(rd_addr0), e.a0);
          check("rd_addr1", 32'(rd_addr1), e.a1);
          check("tw_addr",  32'(tw_addr),  e.tw);
        end
      end
      exp_wr = wr_q.size() > 0 && wr_q[0].cyc == cyc;
      check("wr_en", 32'(wr_en), 32'(exp_wr));
      if (exp_wr) begin
        e = wr_q.pop_front();
        if (wr_en) begin
          check("wr_addr0", 32'(wr_addr0), e.a0);
          check("wr_addr1", 32'(wr_addr1), e.a1);
        end
      end
      check("busy", 32'(busy), 32'(cyc >= busy_lo && cyc <= busy_hi));
      check("done", 32'(done), 32'(cyc == done_cyc));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int c0;
    reset = 1'b1;
    step();
    mon_en = 1'b1;
    step();
    reset = 1'b0;
    idle_from = cyc;
    reset_checks("por");
    repeat (6) cycle_drive(1'b0);

    // First run with forced stray starts in stage 1 and in the DONE cycle.
    run(10, 1'b1);
    // Back-to-back: start on the first idle cycle after done.
    run(0, 1'b0);
    repeat (2) cycle_drive(1'b0);

    // Reset on the second butterfly of stage 1.
    c0 = cyc;
    cycle_drive(1'b1);
    while (cyc < c0 + 1 + P + 1) cycle_drive(1'b0);
    reset = 1'b1;
    purge(cyc);
    step();
    reset = 1'b0;
    idle_from = cyc;
    reset_checks("mid");
    repeat (BF_LAT + 2) cycle_drive(1'b0);
    run(0, 1'b0);

    for (int r = 0; r < 4; r++) begin
      repeat ($urandom_range(0, 4)) cycle_drive(1'b0);
      run(20, 1'b0);
    end
    repeat (4) cycle_drive(1'b0);
    check("rd_q_left", rd_q.size(), 0);
    check("wr_q_left", wr_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
